// File: rtl/lcd_rx.sv
// lcd_rx: byte-serial RGB LCD receiver; assembles pixels and tracks position, line period and bus errors
module lcd_rx #(
    parameter int H_VISIBLE = 320,
    parameter int V_VISIBLE = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  lcd_dat,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_den,
    output logic [23:0] rgb_data,
    output logic        pix_valid,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        frame_start,
    output logic [11:0] h_period,
    output logic        err_partial,
    output logic        err_overrun
);
    typedef enum logic [1:0] {WAIT_VSYNC, WAIT_LINE, ACTIVE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  dat_q;
    logic        hs_q, vs_q, den_q, hs2_q, vs2_q, den2_q;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  r_q, r_d, g_q, g_d;
    logic [23:0] rgb_q, rgb_d;
    logic        pix_q, pix_d, fs_q, fs_d, line_pix_q, line_pix_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [11:0] hcnt_q, hcnt_d, hper_q, hper_d;
    logic        hstart_q, hstart_d, ep_q, ep_d, eo_q, eo_d;
    logic        vs_fall, hs_fall, den_rise, take, line_end, done, drop;

    // Sync inputs idle high, so reset loads them high to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q  <= 8'd0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            den_q  <= 1'b1;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            den2_q <= 1'b1;
        end else begin
            dat_q  <= lcd_dat;
            hs_q   <= lcd_hsync;
            vs_q   <= lcd_vsync;
            den_q  <= lcd_den;
            hs2_q  <= hs_q;
            vs2_q  <= vs_q;
            den2_q <= den_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_VSYNC;
        else       state_q <= state_d;
    end

    always_comb begin
        vs_fall  = vs2_q & ~vs_q;
        state_d  = vs_fall ? WAIT_LINE :
                   (state_q == WAIT_LINE && !den_q) ? ACTIVE :
                   (state_q == ACTIVE && den_q) ? WAIT_LINE : state_q;
    end

    always_comb begin
        hs_fall    = hs2_q & ~hs_q;
        den_rise   = den_q & ~den2_q;
        take       = state_q != WAIT_VSYNC && !den_q && !vs_fall;
        line_end   = state_q == ACTIVE && den_rise && !vs_fall;
        done       = take && phase_q == 2'd2;
        drop       = done && (x_q == 9'(H_VISIBLE) || y_q == 8'(V_VISIBLE));
        phase_d    = (vs_fall || line_end || done) ? 2'd0 : take ? phase_q + 2'd1 : phase_q;
        r_d        = (take && phase_q == 2'd0) ? dat_q : r_q;
        g_d        = (take && phase_q == 2'd1) ? dat_q : g_q;
        pix_d      = done && !drop;
        rgb_d      = pix_d ? {r_q, g_q, dat_q} : rgb_q;
        x_d        = (vs_fall || line_end) ? 9'd0 : pix_q ? x_q + 9'd1 : x_q;
        line_pix_d = (vs_fall || line_end) ? 1'b0 : done ? 1'b1 : line_pix_q;
        y_d        = vs_fall ? 8'd0 :
                     (line_end && line_pix_q && y_q != 8'(V_VISIBLE)) ? y_q + 8'd1 : y_q;
        fs_d       = vs_fall;
        ep_d       = ep_q | (line_end && phase_q != 2'd0);
        eo_d       = eo_q | drop;
        hcnt_d     = hs_fall ? 12'd1 : (hcnt_q == 12'hfff) ? hcnt_q : hcnt_q + 12'd1;
        hstart_d   = hstart_q | hs_fall;
        hper_d     = (hs_fall && hstart_q) ? hcnt_q : hper_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= 2'd0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            rgb_q      <= 24'd0;
            pix_q      <= 1'b0;
            x_q        <= 9'd0;
            y_q        <= 8'd0;
            fs_q       <= 1'b0;
            line_pix_q <= 1'b0;
            hcnt_q     <= 12'd0;
            hper_q     <= 12'd0;
            hstart_q   <= 1'b0;
            ep_q       <= 1'b0;
            eo_q       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            r_q        <= r_d;
            g_q        <= g_d;
            rgb_q      <= rgb_d;
            pix_q      <= pix_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fs_q       <= fs_d;
            line_pix_q <= line_pix_d;
            hcnt_q     <= hcnt_d;
            hper_q     <= hper_d;
            hstart_q   <= hstart_d;
            ep_q       <= ep_d;
            eo_q       <= eo_d;
        end
    end

    assign rgb_data    = rgb_q;
    assign pix_valid   = pix_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign h_period    = hper_q;
    assign err_partial = ep_q;
    assign err_overrun = eo_q;
endmodule

// File: tb/tb_lcd_rx.sv
// tb_lcd_rx: directed vector table plus randomized frames checked against a pixel-stream reference model
module tb_lcd_rx;
    localparam int H = 20;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  lcd_dat = 8'd0;
    logic        lcd_hsync = 1'b1, lcd_vsync = 1'b1, lcd_den = 1'b1;
    logic [23:0] rgb_data;
    logic        pix_valid, frame_start, err_partial, err_overrun;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] h_period;

    always #5 clk = ~clk;

    lcd_rx #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
        .clk(clk), .reset(reset), .lcd_dat(lcd_dat), .lcd_hsync(lcd_hsync),
        .lcd_vsync(lcd_vsync), .lcd_den(lcd_den), .rgb_data(rgb_data),
        .pix_valid(pix_valid), .x(x), .y(y), .frame_start(frame_start),
        .h_period(h_period), .err_partial(err_partial), .err_overrun(err_overrun)
    );

    typedef struct packed {logic [7:0] d; logic h; logic v; logic n;} beat_t;
    localparam beat_t IDLE = {8'h00, 3'b111};

    typedef struct {
        logic [7:0] d; logic v; logic n; logic pv; logic fs;
        logic [23:0] rgb; logic [7:0] y; logic ep;
    } vec_t;
    vec_t tbl [17];

    beat_t stim [$];
    beat_t prev_b;
    int checks = 0, errors = 0;
    int pv_cnt, fs_cnt, last_x, last_y;

    // reference model state: raw-stream view of the protocol
    logic m_ph, m_pv, m_pn, m_armed, m_line_pix, m_ep, m_eo, e_pv, e_fs;
    int m_cyc, m_last_hs, m_nbytes, m_x, m_y, e_x;
    logic [7:0] m_buf [3];
    logic [23:0] m_rgb;
    logic [11:0] m_hp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input beat_t b);
        lcd_dat = b.d; lcd_hsync = b.h; lcd_vsync = b.v; lcd_den = b.n;
    endtask

    task automatic model_reset;
        m_ph = 1'b1; m_pv = 1'b1; m_pn = 1'b1; m_armed = 1'b0; m_line_pix = 1'b0;
        m_ep = 1'b0; m_eo = 1'b0; m_cyc = 0; m_last_hs = -1; m_nbytes = 0;
        m_x = 0; m_y = 0; m_rgb = 24'd0; m_hp = 12'd0; prev_b = IDLE;
    endtask

    task automatic model_step(input beat_t b);
        int col;
        e_pv = 1'b0; e_fs = 1'b0; col = m_x;
        if (!b.h && m_ph) begin
            if (m_last_hs >= 0) m_hp = 12'((m_cyc - m_last_hs) > 4095 ? 4095 : m_cyc - m_last_hs);
            m_last_hs = m_cyc;
        end
        if (!b.v && m_pv) begin
            m_armed = 1'b1; m_x = 0; m_y = 0; m_nbytes = 0; m_line_pix = 1'b0; e_fs = 1'b1;
        end else if (m_armed && b.n && !m_pn) begin
            if (m_nbytes != 0) m_ep = 1'b1;
            if (m_line_pix && m_y < V) m_y++;
            m_nbytes = 0; m_line_pix = 1'b0; m_x = 0;
        end else if (m_armed && !b.n) begin
            m_buf[m_nbytes] = b.d;
            m_nbytes++;
            if (m_nbytes == 3) begin
                m_nbytes = 0; m_line_pix = 1'b1;
                if (m_x >= H || m_y >= V) m_eo = 1'b1;
                else begin
                    e_pv = 1'b1; col = m_x; m_rgb = {m_buf[0], m_buf[1], m_buf[2]}; m_x++;
                end
            end
        end
        e_x = e_pv ? col : m_x;
        m_ph = b.h; m_pv = b.v; m_pn = b.n; m_cyc++;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(IDLE);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset;
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_rgb", 32'(rgb_data), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_h_period", 32'(h_period), 0);
        chk("rst_err_partial", 32'(err_partial), 0);
        chk("rst_err_overrun", 32'(err_overrun), 0);
    endtask

    task automatic push(input logic [7:0] d, input logic h, input logic v, input logic n);
        stim.push_back({d, h, v, n});
    endtask

    task automatic gen_line(input logic v, input int npix, input int extra, input int hw, input int bp, input int fp);
        for (int i = 0; i < hw; i++) push(8'($urandom), 1'b0, v, 1'b1);
        for (int i = 0; i < bp; i++) push(8'($urandom), 1'b1, v, 1'b1);
        for (int i = 0; i < 3 * npix + extra; i++) push(8'($urandom), 1'b1, v, 1'b0);
        for (int i = 0; i < fp; i++) push(8'($urandom), 1'b1, v, 1'b1);
    endtask

    task automatic run;
        pv_cnt = 0; fs_cnt = 0;
        foreach (stim[i]) begin
            drive(stim[i]);
            @(posedge clk);
            #1;
            model_step(prev_b);
            prev_b = stim[i];
            chk("pix_valid", 32'(pix_valid), 32'(e_pv));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("rgb_data", 32'(rgb_data), 32'(m_rgb));
            chk("x", 32'(x), 32'(e_x));
            chk("y", 32'(y), 32'(m_y));
            chk("h_period", 32'(h_period), 32'(m_hp));
            chk("err_partial", 32'(err_partial), 32'(m_ep));
            chk("err_overrun", 32'(err_overrun), 32'(m_eo));
            if (pix_valid) begin pv_cnt++; last_x = int'(x); last_y = int'(y); end
            if (frame_start) fs_cnt++;
        end
        stim.delete();
    endtask

    task automatic setv(input int i, input logic [7:0] d, input logic v, input logic n, input logic pv,
                        input logic fs, input logic [23:0] rgb, input logic [7:0] yy, input logic ep);
        tbl[i].d = d; tbl[i].v = v; tbl[i].n = n; tbl[i].pv = pv;
        tbl[i].fs = fs; tbl[i].rgb = rgb; tbl[i].y = yy; tbl[i].ep = ep;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        setv(0,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0);
        setv(1,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0);
        setv(2,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b0);
        setv(3,  8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0);
        setv(4,  8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0);
        setv(5,  8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0);
        setv(6,  8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 24'h123456, 8'd0, 1'b0);
        setv(7,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b0);
        setv(8,  8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b0);
        setv(9,  8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b0);
        setv(10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b0);
        setv(11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b1);
        setv(12, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b1);
        setv(13, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b1);
        setv(14, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 8'd1, 1'b1);
        setv(15, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 24'h010203, 8'd1, 1'b1);
        setv(16, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 24'h010203, 8'd2, 1'b1);

        do_reset();
        check_reset();

        for (int i = 0; i < 17; i++) begin
            drive({tbl[i].d, 1'b1, tbl[i].v, tbl[i].n});
            @(posedge clk);
            #1;
            chk("tbl_pix_valid", 32'(pix_valid), 32'(tbl[i].pv));
            chk("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
            chk("tbl_rgb", 32'(rgb_data), 32'(tbl[i].rgb));
            chk("tbl_x", 32'(x), 0);
            chk("tbl_y", 32'(y), 32'(tbl[i].y));
            chk("tbl_err_partial", 32'(err_partial), 32'(tbl[i].ep));
            chk("tbl_err_overrun", 32'(err_overrun), 0);
        end

        do_reset();
        gen_line(1'b1, 3, 0, 2, 2, 3);
        gen_line(1'b0, 0, 0, 2, 3, 6);
        gen_line(1'b1, 2, 0, 2, 2, 4);
        run();
        chk("prevsync_pix_count", 32'(pv_cnt), 2);

        do_reset();
        for (int l = 0; l < 10; l++) begin
            int np;
            np = (l >= 2 && l < 8) ? H : 0;
            gen_line(l < 2 ? 1'b0 : 1'b1, np, 0, 6, 9, 90 - 15 - 3 * np);
        end
        run();
        chk("frame_pix_count", 32'(pv_cnt), H * V);
        chk("frame_last_x", 32'(last_x), H - 1);
        chk("frame_last_y", 32'(last_y), V - 1);
        chk("frame_start_count", 32'(fs_cnt), 1);
        chk("frame_h_period", 32'(h_period), 90);
        chk("frame_err_partial", 32'(err_partial), 0);
        chk("frame_err_overrun", 32'(err_overrun), 0);

        gen_line(1'b0, 0, 0, 3, 3, 6);
        gen_line(1'b1, H + 1, 0, 3, 3, 0);
        push(8'h00, 1'b1, 1'b1, 1'b1);
        run();
        chk("ovr_pix_count", 32'(pv_cnt), H);
        chk("ovr_x_held", 32'(x), H);
        chk("ovr_err_overrun", 32'(err_overrun), 1);
        gen_line(1'b1, 2, 0, 2, 2, 4);
        run();
        chk("ovr_x_cleared", 32'(x), 0);
        chk("ovr_err_sticky", 32'(err_overrun), 1);

        do_reset();
        gen_line(1'b0, 0, 0, 2, 2, 4);
        gen_line(1'b1, 0, 2, 2, 2, 4);
        gen_line(1'b1, 1, 0, 2, 2, 4);
        run();
        chk("partial_err", 32'(err_partial), 1);
        chk("partial_pix_count", 32'(pv_cnt), 1);
        chk("partial_next_x", 32'(last_x), 0);

        do_reset();
        gen_line(1'b0, 0, 0, 2, 2, 4);
        gen_line(1'b1, 0, 2, 2, 2, 0);
        run();
        do_reset();
        check_reset();
        gen_line(1'b1, 2, 0, 2, 2, 4);
        run();
        chk("after_reset_no_pix", 32'(pv_cnt), 0);

        do_reset();
        for (int f = 0; f < 25; f++) begin
            if (f == 10) for (int i = 0; i < 4200; i++) stim.push_back(IDLE);
            gen_line(1'b0, 0, 0, $urandom_range(1, 4), $urandom_range(0, 5), $urandom_range(1, 6));
            for (int l = 0, nl = $urandom_range(0, V + 2); l < nl; l++)
                gen_line(1'b1, $urandom_range(0, H + 1), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                         $urandom_range(1, 4), $urandom_range(0, 5), $urandom_range(1, 6));
            run();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_rx.md
LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 Parameter H_VISIBLE, default 320: active pixels per line.
REQ-002 Parameter V_VISIBLE, default 240: active lines per frame.
REQ-003 clk  input  1  single clock; all logic on rising edge; one byte per clk on the bus.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lcd_dat  input  8  byte bus; per pixel R, G, B in consecutive clks.
REQ-006 lcd_hsync  input  1  horizontal sync, active-low.
REQ-007 lcd_vsync  input  1  vertical sync, active-low.
REQ-008 lcd_den  input  1  data enable, active-low (0 = byte valid).
REQ-009 rgb_data  output  24  assembled pixel {R,G,B}.
REQ-010 pix_valid  output  1  one-clk strobe qualifying rgb_data, x, y.
REQ-011 x  output  9  column of current pixel.
REQ-012 y  output  8  row of current pixel.
REQ-013 frame_start  output  1  one-clk pulse on vsync assertion.
REQ-014 h_period  output  12  clks between last two hsync falling edges.
REQ-015 err_partial  output  1  sticky: line ended mid-pixel.
REQ-016 err_overrun  output  1  sticky: pixel beyond H_VISIBLE or V_VISIBLE dropped.

Function
REQ-017 All five bus inputs SHALL be registered once at the input before any use; edge detection uses this stage and one further delayed copy.
REQ-018 FSM states SHALL be WAIT_VSYNC, WAIT_LINE, ACTIVE; reset enters WAIT_VSYNC.
REQ-019 WAIT_VSYNC -> WAIT_LINE on vsync falling edge; bytes before first vsync SHALL be ignored.
REQ-020 WAIT_LINE -> ACTIVE when registered den = 0; ACTIVE -> WAIT_LINE when registered den = 1.
REQ-021 A vsync falling edge in any state SHALL pulse frame_start, clear y to 0, clear x and phase, and enter WAIT_LINE.
REQ-022 In ACTIVE, a 2-bit phase counter SHALL cycle 0,1,2,0: phase 0 captures R, 1 captures G, 2 captures B and completes the pixel.
REQ-023 pix_valid SHALL assert exactly 2 clks after the clk in which the B byte is present at lcd_dat, with rgb_data, x, y stable in that clk.
REQ-024 x SHALL increment by 1 after each emitted pixel and clear to 0 on the den rising edge (line end).
REQ-025 y SHALL increment by 1 on each den rising edge that closes a line containing at least one pixel; it clears only on vsync falling edge.
REQ-026 Den rising edge with phase != 0 SHALL discard the partial pixel, set err_partial, and reset phase to 0.
REQ-027 A pixel completed with x = H_VISIBLE or y = V_VISIBLE SHALL be dropped (no pix_valid), set err_overrun, and leave x and y saturated.
REQ-028 h_period SHALL count clks from one registered hsync falling edge to the next, saturate at 4095, and update on each falling edge; the first edge after reset only starts the count.
REQ-029 Simultaneous vsync and hsync falling edges SHALL apply both REQ-021 and REQ-028.
REQ-030 Reset asserted mid-pixel or mid-line SHALL abandon the pixel with no pix_valid and no error flag set.

Reset
REQ-031 After reset, outputs are rgb_data = 0, pix_valid = 0, x = 0, y = 0, frame_start = 0, h_period = 0, err_partial = 0, err_overrun = 0, state WAIT_VSYNC, phase 0.
REQ-032 Error flags SHALL clear only on reset.

Verification
REQ-033 Full default frame from matching transmitter timing (h_total 408, v_total 262 pixel periods) -> 76800 pix_valid strobes, last at x = 319, y = 239; one frame_start per frame; h_period = 1224.
REQ-034 Bytes 0x12, 0x34, 0x56 with den low after vsync -> rgb_data = 0x123456, x = 0, y = 0, pix_valid 2 clks after 0x56 is presented.
REQ-035 Den high after 2 bytes of a pixel -> err_partial = 1, no pix_valid; next line's first pixel at x = 0 is correct.
REQ-036 Line of 321 pixels -> 320 strobes (x 0..319), err_overrun = 1, x held at 320 until den rises.
REQ-037 Pixel data before first vsync after reset -> no pix_valid until the line after the vsync falling edge.
REQ-038 Reset pulsed during phase 1 of a pixel -> all outputs at REQ-031 values, no error flag, FSM in WAIT_VSYNC.
